// File: rtl/overlay_compositor_if.sv
// overlay_compositor_if: control, camera, sprite ROM and video signals of the compositor
interface overlay_compositor_if #(
    parameter int CH_W = 10,
    parameter int AW   = 14
);
    logic                i_addr_valid;
    logic [19:0]         i_ul_addr;
    logic [19:0]         i_ur_addr;
    logic [19:0]         i_dl_addr;
    logic [19:0]         i_dr_addr;
    logic [1:0]          i_mode;
    logic [23:0]         i_key_color;
    logic                i_pause;
    logic                o_req_cam_data;
    logic [3*CH_W+1:0]   i_cam_data;
    logic [AW-1:0]       o_rom_addr;
    logic [23:0]         i_rom_data;
    logic                o_valid;
    logic [3*CH_W+1:0]   o_data;
    logic                o_frame_start;
    modport slave (
        input  i_addr_valid, i_ul_addr, i_ur_addr, i_dl_addr, i_dr_addr, i_mode, i_key_color, i_pause,
        input  i_cam_data, i_rom_data,
        output o_req_cam_data, o_rom_addr, o_valid, o_data, o_frame_start
    );
    modport master (
        output i_addr_valid, i_ul_addr, i_ur_addr, i_dl_addr, i_dr_addr, i_mode, i_key_color, i_pause,
        output i_cam_data, i_rom_data,
        input  o_req_cam_data, o_rom_addr, o_valid, o_data, o_frame_start
    );
endinterface

// File: rtl/overlay_compositor.sv
// overlay_compositor: raster walker compositing a ROM sprite and corner markers over camera pixels
module overlay_compositor #(
    parameter int H_ACTIVE = 800,
    parameter int H_TOTAL  = 1500,
    parameter int V_ACTIVE = 600,
    parameter int OVL_W    = 128,
    parameter int OVL_H    = 128,
    parameter int MARK     = 8,
    parameter int CH_W     = 10,
    parameter int KEY_EN   = 1
) (
    input logic i_clk,
    input logic i_rst_n,
    overlay_compositor_if.slave bus
);
    localparam int AW      = $clog2(OVL_W * OVL_H);
    localparam int CW      = $clog2(OVL_W);
    localparam int COORD_W = 12;
    localparam int SW      = COORD_W + 2;
    localparam int DW      = 3 * CH_W + 2;
    localparam logic [COORD_W-1:0]   HA   = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0]   HT1  = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0]   VA   = COORD_W'(V_ACTIVE);
    localparam logic signed [SW-1:0] OH   = SW'(OVL_H);
    localparam logic signed [SW-1:0] OW   = SW'(OVL_W);
    localparam logic signed [SW-1:0] HH   = SW'(OVL_H / 2);
    localparam logic signed [SW-1:0] HW   = SW'(OVL_W / 2);
    localparam logic signed [SW-1:0] HALF = SW'(MARK / 2);
    localparam logic [CH_W-1:0]      MX   = '1;
    localparam logic [CH_W-1:0]      Z    = '0;

    logic [COORD_W-1:0]   row, col, s1_row, s1_col, c_row, c_col, sum_r, sum_c;
    logic [19:0]          ul, ur, dl, dr;
    logic [1:0]           mode;
    logic                 s1_win, s1_first, issue, in_win, sprite, m_ul, m_ur, m_dl, m_dr;
    logic signed [SW-1:0] top, left, dy, dx;
    logic [DW-1:0]        sp_px, px;

    function automatic logic near(input logic [COORD_W-1:0] p, input logic [9:0] c);
        logic signed [SW-1:0] d;
        d = $signed({2'b0, p}) - $signed({{(SW-10){1'b0}}, c});
        return d < HALF && d > -HALF;
    endfunction

    function automatic logic [CH_W-1:0] ex(input logic [7:0] d);
        logic [CH_W-1:0] r;
        r = '0;
        r[CH_W-1 -: 8] = d;
        return r;
    endfunction

    always_comb begin
        sum_r  = COORD_W'(bus.i_ul_addr[19:10]) + COORD_W'(bus.i_ur_addr[19:10])
               + COORD_W'(bus.i_dl_addr[19:10]) + COORD_W'(bus.i_dr_addr[19:10]);
        sum_c  = COORD_W'(bus.i_ul_addr[9:0]) + COORD_W'(bus.i_ur_addr[9:0])
               + COORD_W'(bus.i_dl_addr[9:0]) + COORD_W'(bus.i_dr_addr[9:0]);
        top    = $signed({2'b0, c_row}) - HH;
        left   = $signed({2'b0, c_col}) - HW;
        dy     = $signed({2'b0, row}) - top;
        dx     = $signed({2'b0, col}) - left;
        in_win = !dy[SW-1] && dy < OH && !dx[SW-1] && dx < OW;
        // a restart owns the cycle, so the position currently in S0 is never issued
        issue  = row < VA && col < HA && !bus.i_pause && !bus.i_addr_valid;
        m_ul   = mode[1] && near(s1_row, ul[19:10]) && near(s1_col, ul[9:0]);
        m_ur   = mode[1] && near(s1_row, ur[19:10]) && near(s1_col, ur[9:0]);
        m_dl   = mode[1] && near(s1_row, dl[19:10]) && near(s1_col, dl[9:0]);
        m_dr   = mode[1] && near(s1_row, dr[19:10]) && near(s1_col, dr[9:0]);
        sprite = mode[0] && s1_win && !(KEY_EN != 0 && bus.i_rom_data == bus.i_key_color);
        sp_px  = {2'b0, ex(bus.i_rom_data[23:16]), ex(bus.i_rom_data[15:8]), ex(bus.i_rom_data[7:0])};
        px     = m_ul ? {2'b0, MX, Z, MX} : m_ur ? {2'b0, MX, Z, Z} : m_dl ? {2'b0, Z, MX, MX} :
                 m_dr ? {2'b0, Z, Z, MX} : sprite ? sp_px : bus.i_cam_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            row                <= VA;
            col                <= '0;
            ul                 <= '0;
            ur                 <= '0;
            dl                 <= '0;
            dr                 <= '0;
            mode               <= '0;
            c_row              <= '0;
            c_col              <= '0;
            s1_row             <= '0;
            s1_col             <= '0;
            s1_win             <= 1'b0;
            s1_first           <= 1'b0;
            bus.o_req_cam_data <= 1'b0;
            bus.o_rom_addr     <= '0;
            bus.o_valid        <= 1'b0;
            bus.o_data         <= '0;
            bus.o_frame_start  <= 1'b0;
        end else begin
            if (bus.i_addr_valid) begin
                ul    <= bus.i_ul_addr;
                ur    <= bus.i_ur_addr;
                dl    <= bus.i_dl_addr;
                dr    <= bus.i_dr_addr;
                mode  <= bus.i_mode;
                c_row <= sum_r >> 2;
                c_col <= sum_c >> 2;
                row   <= '0;
                col   <= '0;
            end else if (!bus.i_pause && row < VA) begin
                col <= (col == HT1) ? '0 : col + 1'b1;
                row <= (col == HT1) ? row + 1'b1 : row;
            end
            bus.o_req_cam_data <= issue;
            if (issue) begin
                s1_row   <= row;
                s1_col   <= col;
                s1_win   <= in_win;
                s1_first <= row == '0 && col == '0;
            end
            if (issue && in_win)
                bus.o_rom_addr <= {dy[AW-CW-1:0], dx[CW-1:0]};
            bus.o_valid       <= bus.o_req_cam_data && !bus.i_addr_valid;
            bus.o_frame_start <= bus.o_req_cam_data && s1_first && !bus.i_addr_valid;
            if (bus.o_req_cam_data)
                bus.o_data <= px;
        end
    end
endmodule
